// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit queue
package uart_pkg;

    localparam int UART_TX_DEPTH = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_START,
        S_WAIT_END
    } tx_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - CPU write, transmitter handshake and interrupt signals of the transmit queue
interface uart_tx_queue_if;
    import uart_pkg::*;

    logic  w_req;
    byte_t w_data;
    logic  full;
    logic  overrun;
    logic  send_req;
    byte_t send_data;
    logic  busy;
    logic  irr_tx;
    logic  ack_tx;

    modport slave (
        input  w_req, w_data, busy, ack_tx,
        output full, overrun, send_req, send_data, irr_tx
    );

    modport master (
        output w_req, w_data, busy, ack_tx,
        input  full, overrun, send_req, send_data, irr_tx
    );
endinterface

// File: rtl/uart_tx_queue_byte_fifo.sv
// rtl/uart_tx_queue_byte_fifo.sv - synchronous byte FIFO with registered count/full/empty
module byte_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = UART_TX_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  byte_t         din,
    input  logic          pop,
    output byte_t         dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    byte_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok;
    logic          pop_ok;

    // Requests against a full or empty FIFO are ignored, never wrapped over.
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        full_d   = (count_d == (AW+1)'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - buffered UART transmit queue draining a FIFO through send_req/busy
// Optional drain-complete interrupt enabled by defining UART_TX_INTR_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int  DEPTH = UART_TX_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_queue_if.slave  bus
);

    tx_state_t   state_q, state_d;
    logic        send_req_q, send_req_d;
    byte_t       send_data_q, send_data_d;
    logic        overrun_q, overrun_d;
    logic        fifo_pop;
    byte_t       fifo_dout;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_ok;
    logic        drop;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.w_req),
        .din   (bus.w_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // full is registered, so a write in the cycle after the FIFO fills is dropped
    // even if the FSM pops in that same cycle.
    assign push_ok = bus.w_req && !fifo_full;
    assign drop    = bus.w_req && fifo_full;

    always_comb begin
        state_d     = state_q;
        send_req_d  = 1'b0;
        send_data_d = send_data_q;
        fifo_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((fifo_count != '0) && !bus.busy) begin
                    fifo_pop    = 1'b1;
                    send_data_d = fifo_dout;
                    send_req_d  = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ:        state_d = S_WAIT_START;
            S_WAIT_START: if (bus.busy) state_d = S_WAIT_END;
            S_WAIT_END:   if (!bus.busy) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.ack_tx) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            send_req_q  <= 1'b0;
            send_data_q <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            send_req_q  <= send_req_d;
            send_data_q <= send_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.full      = fifo_full;
    assign bus.overrun   = overrun_q;
    assign bus.send_req  = send_req_q;
    assign bus.send_data = send_data_q;

`ifdef UART_TX_INTR_EN
    logic irr_tx_q, irr_tx_d;
    logic drain_done;

    // Drained means the frame just ended, nothing is queued and nothing is arriving.
    always_comb begin
        drain_done = (state_q == S_WAIT_END) && !bus.busy && fifo_empty && !push_ok;
        irr_tx_d   = irr_tx_q;
        if (drain_done) begin
            irr_tx_d = 1'b1;
        end else if (bus.ack_tx) begin
            irr_tx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr_tx_q <= 1'b0;
        end else begin
            irr_tx_q <= irr_tx_d;
        end
    end

    assign bus.irr_tx = irr_tx_q;
`else
    logic unused_empty;
    assign unused_empty = fifo_empty;
    assign bus.irr_tx   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed self-checking bench for uart_tx_queue with a transmitter model
module tb_uart_tx_queue;
    import uart_pkg::*;

`ifdef UART_TX_INTR_EN
    localparam logic INTR = 1'b1;
`else
    localparam logic INTR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_queue_if bus();

    uart_tx_queue #(.DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Transmitter model: busy rises the cycle after send_req and stays high frame_len cycles.
    logic  busy_force = 1'b0;
    logic  busy_m     = 1'b0;
    logic  pend       = 1'b0;
    int    rem        = 0;
    int    frame_len  = 100;
    int    req_count  = 0;
    int    req_while_busy = 0;
    byte_t sent[$];

    assign bus.busy = busy_force | busy_m;

    always @(negedge clk) begin
        if (bus.send_req) begin
            req_count++;
            sent.push_back(bus.send_data);
            if (bus.busy) req_while_busy++;
        end
        if (pend) begin
            busy_m = 1'b1;
            rem    = frame_len;
            pend   = 1'b0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) busy_m = 1'b0;
        end
        if (bus.send_req) pend = 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_reqs(input string tag, input int n, input int bound);
        for (int i = 0; i < bound && req_count < n; i++) step();
        chk(tag, req_count, n);
    endtask

    task automatic wait_quiet(input string tag, input int bound);
        for (int i = 0; i < bound && (bus.busy || pend || rem != 0); i++) step();
        chk(tag, {31'd0, bus.busy}, 32'd0);
        step();
        step();
    endtask

    task automatic write_byte(input byte_t b);
        bus.w_data = b;
        bus.w_req  = 1'b1;
        step();
        bus.w_req  = 1'b0;
    endtask

    task automatic ack();
        bus.ack_tx = 1'b1;
        step();
        bus.ack_tx = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus.w_req  = 1'b0;
        bus.w_data = 8'h00;
        bus.ack_tx = 1'b0;
        step();
        step();
        chk("rst_full",      {31'd0, bus.full},     32'd0);
        chk("rst_overrun",   {31'd0, bus.overrun},  32'd0);
        chk("rst_send_req",  {31'd0, bus.send_req}, 32'd0);
        chk("rst_send_data", {24'd0, bus.send_data}, 32'h00);
        chk("rst_irr",       {31'd0, bus.irr_tx},   32'd0);
        reset = 1'b0;
        step();

        // Single byte: write in cycle 0, send_req in cycle 2.
        frame_len  = 100;
        bus.w_data = 8'h41;
        bus.w_req  = 1'b1;
        step();
        bus.w_req  = 1'b0;
        chk("single_c1_req", {31'd0, bus.send_req}, 32'd0);
        step();
        chk("single_c2_req",  {31'd0, bus.send_req}, 32'd1);
        chk("single_c2_data", {24'd0, bus.send_data}, 32'h41);
        for (int i = 0; i < 120; i++) step();
        chk("single_count", req_count, 1);
        chk("single_byte",  {24'd0, sent[0]}, 32'h41);
        chk("single_irr",   {31'd0, bus.irr_tx}, {31'd0, INTR});
        ack();
        chk("single_irr_ack", {31'd0, bus.irr_tx}, 32'd0);

        // Burst of five bytes.
        frame_len = 10;
        for (int i = 1; i <= 5; i++) write_byte(byte_t'(i));
        wait_reqs("burst_reqs", 6, 300);
        wait_quiet("burst_quiet", 50);
        for (int i = 1; i <= 5; i++) chk($sformatf("burst_byte%0d", i), {24'd0, sent[i]}, i);
        chk("burst_req_while_busy", req_while_busy, 0);
        ack();

        // Fill with busy held, then overflow twice (second with a coinciding ack).
        busy_force = 1'b1;
        step();
        for (int i = 0; i < 18; i++) begin
            bus.w_data = byte_t'(8'h10 + i);
            bus.w_req  = 1'b1;
            bus.ack_tx = (i == 17);
            step();
            if (i == 14) chk("fill_not_full_15", {31'd0, bus.full}, 32'd0);
            if (i == 15) begin
                chk("fill_full_16",   {31'd0, bus.full},    32'd1);
                chk("fill_no_overrun", {31'd0, bus.overrun}, 32'd0);
            end
            if (i == 16) chk("fill_overrun",          {31'd0, bus.overrun}, 32'd1);
            if (i == 17) chk("fill_overrun_set_wins", {31'd0, bus.overrun}, 32'd1);
        end
        bus.w_req  = 1'b0;
        bus.ack_tx = 1'b0;
        chk("fill_still_full", {31'd0, bus.full}, 32'd1);
        ack();
        chk("fill_overrun_ack", {31'd0, bus.overrun}, 32'd0);
        busy_force = 1'b0;
        wait_reqs("fill_reqs", 22, 500);
        wait_quiet("fill_quiet", 50);
        for (int i = 0; i < 5; i++) step();
        chk("fill_exact_count", req_count, 22);
        for (int j = 0; j < 16; j++) chk($sformatf("fill_byte%0d", j), {24'd0, sent[6+j]}, 32'h10 + j);
        chk("fill_drained_full", {31'd0, bus.full}, 32'd0);

        // Drain interrupt on two bytes, then set-beats-ack on one byte.
        ack();
        chk("irq_pre", {31'd0, bus.irr_tx}, 32'd0);
        write_byte(8'h51);
        write_byte(8'h52);
        wait_reqs("irq_reqs", 24, 200);
        chk("irq_mid", {31'd0, bus.irr_tx}, 32'd0);
        wait_quiet("irq_quiet", 50);
        chk("irq_raised", {31'd0, bus.irr_tx}, {31'd0, INTR});
        ack();
        chk("irq_ack", {31'd0, bus.irr_tx}, 32'd0);
        write_byte(8'h53);
        wait_reqs("irq2_reqs", 25, 100);
        for (int i = 0; i < 100 && rem != 1; i++) step();
        chk("irq2_frame_end", rem, 1);
        ack();
        chk("irq_set_wins", {31'd0, bus.irr_tx}, {31'd0, INTR});
        ack();
        chk("irq2_ack", {31'd0, bus.irr_tx}, 32'd0);
        wait_quiet("irq2_quiet", 50);

        // Push in the same cycle as the IDLE pop of a single queued byte.
        write_byte(8'hA1);
        write_byte(8'hA2);
        chk("simul_full", {31'd0, bus.full}, 32'd0);
        wait_reqs("simul_reqs", 27, 200);
        wait_quiet("simul_quiet", 50);
        for (int i = 0; i < 3; i++) step();
        chk("simul_exact",  req_count, 27);
        chk("simul_first",  {24'd0, sent[25]}, 32'hA1);
        chk("simul_second", {24'd0, sent[26]}, 32'hA2);

        // Reset while waiting for the end of a frame with three bytes queued.
        frame_len = 40;
        for (int i = 0; i < 4; i++) write_byte(byte_t'(8'h61 + i));
        wait_reqs("rstmid_reqs", 28, 100);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1;
        chk("rstmid_send_req",  {31'd0, bus.send_req}, 32'd0);
        chk("rstmid_send_data", {24'd0, bus.send_data}, 32'h00);
        chk("rstmid_full",      {31'd0, bus.full}, 32'd0);
        chk("rstmid_overrun",   {31'd0, bus.overrun}, 32'd0);
        chk("rstmid_irr",       {31'd0, bus.irr_tx}, 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 60; i++) step();
        chk("rstmid_no_req", req_count, 28);
        chk("rstmid_busy_done", {31'd0, bus.busy}, 32'd0);
        frame_len = 10;
        write_byte(8'h77);
        wait_reqs("rstmid_new_req", 29, 100);
        wait_quiet("rstmid_quiet", 50);
        chk("rstmid_new_byte", {24'd0, sent[28]}, 32'h77);
        chk("final_req_while_busy", req_while_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered transmit path between the CPU and the UART `transmitter`: the transmit-side counterpart of the `receiver` + `uart_intr` receive path. The CPU pushes bytes into an internal FIFO without waiting on `busy`. A state machine drains the FIFO one byte at a time through the transmitter's `send_req`/`busy` handshake. An optional interrupt is raised when the queue has fully drained.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`, pointer width (derived; do not override).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `w_req`  in  1  CPU write strobe; one byte per cycle high.
- `w_data`  in  8  byte written when `w_req`.
- `full`  out  1  registered; count == DEPTH.
- `overrun`  out  1  sticky; set when a write is dropped because the FIFO is full.
- `send_req`  out  1  one-cycle request to the transmitter.
- `send_data`  out  8  byte for the transmitter; stable from `send_req` until the FSM returns to IDLE.
- `busy`  in  1  transmitter busy flag.
- `irr_tx`  out  1  drain-complete interrupt (see Configuration).
- `ack_tx`  in  1  one-cycle interrupt acknowledge; also clears `overrun`.

## Operation
- **FIFO**
  - Write accepted when `w_req && !full`.
  - Count range is 0..DEPTH (AW+1 bits).
  - Pointers wrap modulo DEPTH.
- **Write while full:** the byte is dropped and `overrun` is set. This holds even if a pop occurs in the same cycle, because `full` is registered.
- **FSM states**
  - `S_IDLE`: if count ≠ 0 and `!busy`, pop the head into `send_data`, then go to `S_REQ`.
  - `S_REQ`: `send_req` = 1 for exactly this cycle, then go to `S_WAIT_START`.
  - `S_WAIT_START`: wait for `busy` = 1, then go to `S_WAIT_END`.
  - `S_WAIT_END`: wait for `busy` = 0, then go to `S_IDLE`.
- **Simultaneous push and pop:** both occur; count is unchanged.
- **Push into an empty FIFO:** the byte is not bypassed. The earliest pop is the next cycle.
- **Reset mid-transfer:** FSM returns to `S_IDLE` and FIFO contents are discarded. The transmitter finishes its current frame independently. No `send_req` is issued until `busy` is low.
- **`overrun` clearing:** cleared by `ack_tx`. If a drop and `ack_tx` occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - `full` = 0
  - `overrun` = 0
  - `send_req` = 0
  - `send_data` = 8'h00
  - `irr_tx` = 0
  - FSM = `S_IDLE`
  - count = 0
- **Latency with empty FIFO, idle FSM and `busy` = 0:**
  - `w_req` in cycle 0.
  - Count = 1 in cycle 1; pop in cycle 1.
  - `send_req` high in cycle 2.
- **Back-to-back bytes:** the next `send_req` comes no earlier than 2 cycles after `busy` falls (IDLE pop, then REQ).
- **Outputs:** all registered; no combinational path from any input to any output.
- **`full`:** updates the cycle after the accepted write or pop that changes count.

## Configuration
- **Macro:** `UART_TX_INTR_EN`.
- **Defined:** `irr_tx` is set on the `S_WAIT_END` → `S_IDLE` transition when count == 0 and no write is accepted that cycle. It holds until `ack_tx`; if set and `ack_tx` coincide, set wins.
- **Undefined:**
  - `irr_tx` is tied to 0.
  - `ack_tx` only clears `overrun`.
  - Interrupt logic is absent.

## Structure
- **Package `uart_pkg`:**
  - FSM enum `tx_state_t` (`S_IDLE`, `S_REQ`, `S_WAIT_START`, `S_WAIT_END`).
  - Constant `UART_TX_DEPTH` = 16.
  - Byte typedef `byte_t` (logic [7:0]).
- **Sub-module `byte_fifo`:**
  - Parameter `DEPTH`.
  - Synchronous FIFO: push, pop, `dout`, count, full, empty.
  - Async active-high reset.
- **Top level:** `uart_tx_queue` holds the FSM, the `overrun` flag and the interrupt.

## Test plan
- **Single byte:** write 8'h41 in cycle 0 with `busy` = 0 → `send_req` pulses in cycle 2 with `send_data` = 8'h41. Transmitter model raises `busy` 1 cycle later for 100 cycles → exactly one `send_req`.
- **Burst:** write 8'h01..8'h05 on consecutive cycles → five `send_req` pulses in order 01..05, each after the prior `busy` fall, never while `busy` = 1.
- **Fill and overrun:** with `busy` held at 1, write 17 bytes (DEPTH = 16) → `full` = 1 after the 16th write, 17th byte dropped, `overrun` = 1. Then `ack_tx` → `overrun` = 0, and only 16 bytes are sent once `busy` releases.
- **Drain interrupt (macro defined):** send 2 bytes → `irr_tx` rises on return to IDLE after the 2nd frame. `ack_tx` clears it; a coinciding set beats ack. Macro undefined → `irr_tx` stays 0.
- **Reset mid-transfer:** assert `reset` during `S_WAIT_END` with 3 bytes queued → all outputs at reset values immediately. After release, no `send_req` until new writes arrive.
- **Simultaneous push/pop:** count = 1 and IDLE pop in the same cycle as a write → count stays 1, and order is preserved.
